// File: rtl/mux_tx_defs.sv
// rtl/mux_tx_defs.sv - shared constants and types for the 4-lane TX byte multiplexer
package mux_tx_defs;

    localparam int          NUM_LANES     = 4;
    localparam int          FASE_W        = 2;
    localparam logic [7:0]  COMMA_K285    = 8'hBC;
    localparam logic [7:0]  IDLE_BYTE_DEF = 8'h00;

    typedef logic [FASE_W-1:0] fase_t;

    // Lane index emitted on an edge whose pre-increment phase is fase.
    function automatic fase_t lane_sel(input fase_t fase);
        return fase - fase_t'(1);
    endfunction

    function automatic fase_t fase_next(input fase_t fase);
        return fase + fase_t'(1);
    endfunction

endpackage

// File: rtl/mux4x1_tx_if.sv
// rtl/mux4x1_tx_if.sv - lane inputs and serial output bundle of the TX byte multiplexer
interface mux4x1_tx_if #(
    parameter int BW = 8
);
    logic [BW-1:0] Entrada0;
    logic [BW-1:0] Entrada1;
    logic [BW-1:0] Entrada2;
    logic [BW-1:0] Entrada3;
    logic          validEntrada0;
    logic          validEntrada1;
    logic          validEntrada2;
    logic          validEntrada3;
    logic [BW-1:0] Salida;
    logic          validSalida;
    logic          inicio_trama;

    modport master (
        output Entrada0, Entrada1, Entrada2, Entrada3,
        output validEntrada0, validEntrada1, validEntrada2, validEntrada3,
        input  Salida, validSalida, inicio_trama
    );

    modport slave (
        input  Entrada0, Entrada1, Entrada2, Entrada3,
        input  validEntrada0, validEntrada1, validEntrada2, validEntrada3,
        output Salida, validSalida, inicio_trama
    );

endinterface

// File: rtl/mux4x1_tx_contador_fase.sv
// rtl/mux4x1_tx_contador_fase.sv - wrapping frame phase counter with a phase-zero strobe
module contador_fase
    import mux_tx_defs::*;
(
    input  logic  clk_i,
    input  logic  resetn_i,
    output fase_t fase_o,
    output logic  fase_cero_o
);

    fase_t fase_q;
    fase_t fase_d;

    always_comb begin
        fase_d = fase_next(fase_q);
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            fase_q <= '0;
        end else begin
            fase_q <= fase_d;
        end
    end

    assign fase_o      = fase_q;
    assign fase_cero_o = (fase_q == '0);

endmodule

// File: rtl/mux4x1_tx.sv
// rtl/mux4x1_tx.sv - serialises four byte lanes into one stream, one lane per cycle
// Optional MUX_IDLE_COMMA_EN: invalid slots carry the K28.5 comma instead of IDLE_BYTE.
module mux4x1_tx
    import mux_tx_defs::*;
#(
    parameter int            BW        = 8,
    parameter logic [BW-1:0] IDLE_BYTE = BW'(IDLE_BYTE_DEF)
) (
    input  logic        clk_4f,
    input  logic        reset,
    mux4x1_tx_if.slave  bus
);

`ifdef MUX_IDLE_COMMA_EN
    localparam logic [BW-1:0] FILL_BYTE = BW'(COMMA_K285);

    if (BW != 8) begin : g_bw_check
        $error("mux4x1_tx: BW must be 8 when the comma fill is enabled");
    end
`else
    localparam logic [BW-1:0] FILL_BYTE = IDLE_BYTE;
`endif

    logic [BW-1:0] lane_data  [NUM_LANES];
    logic          lane_valid [NUM_LANES];

    assign lane_data[0]  = bus.Entrada0;
    assign lane_data[1]  = bus.Entrada1;
    assign lane_data[2]  = bus.Entrada2;
    assign lane_data[3]  = bus.Entrada3;
    assign lane_valid[0] = bus.validEntrada0;
    assign lane_valid[1] = bus.validEntrada1;
    assign lane_valid[2] = bus.validEntrada2;
    assign lane_valid[3] = bus.validEntrada3;

    fase_t fase;
    logic  fase_cero;
    fase_t sel;

    contador_fase u_contador_fase (
        .clk_i       (clk_4f),
        .resetn_i    (reset),
        .fase_o      (fase),
        .fase_cero_o (fase_cero)
    );

    assign sel = lane_sel(fase);

    logic [BW-1:0] buf_q  [NUM_LANES];
    logic [BW-1:0] buf_d  [NUM_LANES];
    logic          vbuf_q [NUM_LANES];
    logic          vbuf_d [NUM_LANES];
    logic [BW-1:0] salida_q;
    logic [BW-1:0] salida_d;
    logic          valid_q;
    logic          valid_d;
    logic          inicio_q;
    logic          inicio_d;

    // Emission reads the buffer before this edge's capture lands, so the lane-3
    // slot of the old frame and the capture of the new frame share one edge.
    always_comb begin
        for (int k = 0; k < NUM_LANES; k++) begin
            buf_d[k]  = buf_q[k];
            vbuf_d[k] = vbuf_q[k];
        end
        if (fase_cero) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                buf_d[k]  = lane_data[k];
                vbuf_d[k] = lane_valid[k];
            end
        end
        salida_d = vbuf_q[sel] ? buf_q[sel] : FILL_BYTE;
        valid_d  = vbuf_q[sel];
        inicio_d = (sel == '0);
    end

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            for (int k = 0; k < NUM_LANES; k++) begin
                buf_q[k]  <= '0;
                vbuf_q[k] <= 1'b0;
            end
            salida_q <= IDLE_BYTE;
            valid_q  <= 1'b0;
            inicio_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_LANES; k++) begin
                buf_q[k]  <= buf_d[k];
                vbuf_q[k] <= vbuf_d[k];
            end
            salida_q <= salida_d;
            valid_q  <= valid_d;
            inicio_q <= inicio_d;
        end
    end

    assign bus.Salida       = salida_q;
    assign bus.validSalida  = valid_q;
    assign bus.inicio_trama = inicio_q;

endmodule
